// File: rtl/uart_cmd_master.sv
// uart_cmd_master
//   Host-side initiator for the UART command protocol. Accepts one command,
//   sends its frame bytes one at a time to a UART transmitter, collects the
//   response bytes from a UART receiver and reports them as one result word.
//
//   Optional build macro: UART_CMD_MASTER_TIMEOUT_EN
//     defined   : a stalled command is aborted after TIMEOUT_CYCLES idle cycles
//                 and completes with RSP_TIMEOUT=1.
//     undefined : the master waits indefinitely; RSP_TIMEOUT is always 0.
//
// Ports
//   CLK, RST                  clock, asynchronous active-low reset
//   CMD_VALID / CMD_READY     command handshake (READY only in IDLE)
//   CMD_TYPE                  0=RF_WR 1=RF_RD 2=ALU_OP 3=ALU_NOP
//   CMD_ADDR, CMD_WDATA       register address / write data
//   CMD_OP_A, CMD_OP_B        ALU operands
//   CMD_FUNC                  ALU function
//   TX_DATA / TX_DATA_VALID   byte offered to the transmitter
//   TX_BUSY                   transmitter busy
//   RX_DATA / RX_DATA_VALID   received byte, one-cycle strobe
//   RSP_DATA                  response word (first byte in the low half)
//   RSP_VALID                 one-cycle completion pulse
//   RSP_TIMEOUT               qualifies RSP_VALID: command aborted
module uart_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUNC_WIDTH     = 4,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [1:0]              CMD_TYPE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH-1:0]   CMD_OP_A,
  input  logic [DATA_WIDTH-1:0]   CMD_OP_B,
  input  logic [FUNC_WIDTH-1:0]   CMD_FUNC,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_DATA_VALID,
  input  logic                    TX_BUSY,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_DATA_VALID,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VALID,
  output logic                    RSP_TIMEOUT
);

  localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HDR_NOP = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO, S_RECV, S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              cmd_type;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata, cmd_op_a, cmd_op_b;
  logic [FUNC_WIDTH-1:0]   cmd_func;
  logic [2:0]              byte_idx;   // number of frame bytes already consumed
  logic [1:0]              rsp_cnt;    // number of response bytes captured
  logic [2*DATA_WIDTH-1:0] rsp_data;
  logic [DATA_WIDTH-1:0]   cur_byte;
  logic [2:0]              n_bytes;
  logic [1:0]              n_rsp;
  logic                    accept, consume, last_sent, rx_en, rx_take, tmo_hit;

  function automatic logic [2:0] frame_len(input logic [1:0] t);
    case (t)
      2'd0:    return 3'd3;
      2'd2:    return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(input logic [1:0] t);
    case (t)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  assign n_bytes   = frame_len(cmd_type);
  assign n_rsp     = rsp_len(cmd_type);
  assign accept    = (state == S_IDLE) && CMD_VALID;
  assign consume   = (state == S_SEND) && !TX_BUSY;
  assign last_sent = (byte_idx == n_bytes);
  // Capture window opens the cycle after the last frame byte is consumed.
  assign rx_en     = (((state == S_WAIT_HI) || (state == S_WAIT_LO)) && last_sent) ||
                     (state == S_RECV);
  assign rx_take   = rx_en && RX_DATA_VALID && (rsp_cnt != n_rsp);

  always_comb begin
    cur_byte = '0;
    case (cmd_type)
      2'd0: begin
        if (byte_idx == 3'd0)      cur_byte = HDR_WR;
        else if (byte_idx == 3'd1) cur_byte = DATA_WIDTH'(cmd_addr);
        else                       cur_byte = cmd_wdata;
      end
      2'd1: cur_byte = (byte_idx == 3'd0) ? HDR_RD : DATA_WIDTH'(cmd_addr);
      2'd2: begin
        if (byte_idx == 3'd0)      cur_byte = HDR_ALU;
        else if (byte_idx == 3'd1) cur_byte = cmd_op_a;
        else if (byte_idx == 3'd2) cur_byte = cmd_op_b;
        else                       cur_byte = DATA_WIDTH'(cmd_func);
      end
      default: cur_byte = (byte_idx == 3'd0) ? HDR_NOP : DATA_WIDTH'(cmd_func);
    endcase
  end

`ifdef UART_CMD_MASTER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic                     counting, timed_out;

  assign counting = (state == S_WAIT_HI) || (state == S_WAIT_LO) || (state == S_RECV);
  // The edge that would bring the counter to TIMEOUT_CYCLES aborts instead.
  assign tmo_hit  = counting && (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                              tmo_cnt <= '0;
    else if ((state_nxt != state) || rx_take) tmo_cnt <= '0;
    else if (counting)                     tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        timed_out <= 1'b0;
    else if (accept) timed_out <= 1'b0;
    else if (tmo_hit && (state_nxt == S_DONE)) timed_out <= 1'b1;
  end

  assign RSP_TIMEOUT = (state == S_DONE) && timed_out;
`else
  logic unused_tmo;
  // Timeout parameters only matter in the timeout build.
  assign unused_tmo  = |TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  assign tmo_hit     = 1'b0;
  assign RSP_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (CMD_VALID) state_nxt = S_SEND;
      S_SEND:    if (!TX_BUSY)  state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (TX_BUSY)   state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!TX_BUSY) begin
          if (!last_sent)          state_nxt = S_SEND;
          else if (n_rsp == 2'd0)  state_nxt = S_DONE;
          else                     state_nxt = S_RECV;
        end
      end
      S_RECV:    if (rsp_cnt == n_rsp) state_nxt = S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
    if (tmo_hit && (state_nxt == state)) state_nxt = S_DONE;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_type  <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_op_a  <= '0;
      cmd_op_b  <= '0;
      cmd_func  <= '0;
      byte_idx  <= '0;
      rsp_cnt   <= '0;
      rsp_data  <= '0;
    end else if (accept) begin
      cmd_type  <= CMD_TYPE;
      cmd_addr  <= CMD_ADDR;
      cmd_wdata <= CMD_WDATA;
      cmd_op_a  <= CMD_OP_A;
      cmd_op_b  <= CMD_OP_B;
      cmd_func  <= CMD_FUNC;
      byte_idx  <= '0;
      rsp_cnt   <= '0;
      rsp_data  <= '0;
    end else begin
      if (consume) byte_idx <= byte_idx + 1'b1;
      if (rx_take) begin
        if (rsp_cnt == 2'd0) rsp_data[DATA_WIDTH-1:0]            <= RX_DATA;
        else                 rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_DATA;
        rsp_cnt <= rsp_cnt + 1'b1;
      end
    end
  end

  assign CMD_READY     = (state == S_IDLE);
  assign TX_DATA_VALID = (state == S_SEND);
  assign TX_DATA       = (state == S_SEND) ? cur_byte : '0;
  assign RSP_VALID     = (state == S_DONE);
  assign RSP_DATA      = rsp_data;

endmodule

// File: tb/tb_uart_cmd_master.sv
module tb_uart_cmd_master;

  logic        CLK, RST;
  logic        CMD_VALID, CMD_READY;
  logic [1:0]  CMD_TYPE;
  logic [3:0]  CMD_ADDR, CMD_FUNC;
  logic [7:0]  CMD_WDATA, CMD_OP_A, CMD_OP_B;
  logic [7:0]  TX_DATA, RX_DATA;
  logic        TX_DATA_VALID, TX_BUSY, RX_DATA_VALID;
  logic [15:0] RSP_DATA;
  logic        RSP_VALID, RSP_TIMEOUT;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_seen[$];   // bytes taken by the transmitter model
  logic [7:0]  exp_tx[$];    // scoreboard: expected frame bytes
  logic [15:0] exp_rsp[$];   // scoreboard: expected response words

  uart_cmd_master #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUNC_WIDTH(4),
    .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_OP_A(CMD_OP_A),
    .CMD_OP_B(CMD_OP_B), .CMD_FUNC(CMD_FUNC),
    .TX_DATA(TX_DATA), .TX_DATA_VALID(TX_DATA_VALID), .TX_BUSY(TX_BUSY),
    .RX_DATA(RX_DATA), .RX_DATA_VALID(RX_DATA_VALID),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Transmitter model: takes a byte when offered while idle, then stays
  // busy for 10 cycles.
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (TX_DATA_VALID && !TX_BUSY) begin
        tx_seen.push_back(TX_DATA);
        @(negedge CLK);
        TX_BUSY = 1'b1;
        repeat (10) @(negedge CLK);
        TX_BUSY = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] b);
    RX_DATA = b;
    RX_DATA_VALID = 1'b1;
    @(negedge CLK);
    RX_DATA_VALID = 1'b0;
    RX_DATA = 8'h00;
  endtask

  // Issues one command, plays the receiver side and waits (bounded) for RSP_VALID.
  task automatic drive_cmd(input logic [1:0] t, input logic [3:0] addr,
                           input logic [7:0] wd, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] fn,
                           input int nbytes, input int nrep,
                           input logic [7:0] r0, input logic [7:0] r1,
                           input bit stray, output bit got,
                           output logic [15:0] data, output logic tmo);
    got = 1'b0;
    data = '0;
    tmo = 1'b0;
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_TYPE = t; CMD_ADDR = addr; CMD_WDATA = wd;
    CMD_OP_A = a; CMD_OP_B = b; CMD_FUNC = fn;
    for (int w = 0; w < 50 && !CMD_READY; w++) @(negedge CLK);
    @(negedge CLK);
    // Scramble inputs: the master must use its registered copy.
    CMD_VALID = 1'b0;
    CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom); CMD_WDATA = 8'($urandom);
    CMD_OP_A = 8'($urandom); CMD_OP_B = 8'($urandom); CMD_FUNC = 4'($urandom);
    fork
      begin
        if (stray) begin
          for (int k = 0; k < 200 && !TX_DATA_VALID; k++) @(negedge CLK);
          send_rx(8'hFF);
        end
        if (nrep > 0) begin
          for (int k = 0; k < 2000 && tx_seen.size() < nbytes; k++) @(negedge CLK);
          repeat (3) @(negedge CLK);
          send_rx(r0);
          @(negedge CLK);
          if (nrep > 1) send_rx(r1);
        end
      end
      begin
        for (int c = 0; c < 3000; c++) begin
          @(negedge CLK);
          if (RSP_VALID) begin
            got = 1'b1;
            data = RSP_DATA;
            tmo = RSP_TIMEOUT;
            break;
          end
        end
      end
    join
  endtask

  task automatic test_reset;
    RST = 1'b0;
    CMD_VALID = 1'b0; CMD_TYPE = '0; CMD_ADDR = '0; CMD_WDATA = '0;
    CMD_OP_A = '0; CMD_OP_B = '0; CMD_FUNC = '0;
    RX_DATA = '0; RX_DATA_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({CMD_READY, TX_DATA_VALID, TX_DATA, RSP_DATA, RSP_VALID, RSP_TIMEOUT} !== {1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b txv=%b tx=%h rsp=%h rv=%b to=%b, required 1 0 00 0000 0 0",
               CMD_READY, TX_DATA_VALID, TX_DATA, RSP_DATA, RSP_VALID, RSP_TIMEOUT);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_rf_wr;
    bit got; logic [15:0] d; logic to; logic [7:0] e, o;
    tx_seen.delete();
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'h03); exp_tx.push_back(8'h5A);
    exp_rsp.push_back(16'h0000);
    drive_cmd(2'd0, 4'd3, 8'h5A, 8'h00, 8'h00, 4'd0, 3, 0, 8'h00, 8'h00, 1'b0, got, d, to);
    checks++;
    if (tx_seen.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL rf_wr_frame_len: got %0d bytes, required %0d", tx_seen.size(), exp_tx.size());
    end
    while (exp_tx.size() > 0 && tx_seen.size() > 0) begin
      e = exp_tx.pop_front(); o = tx_seen.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rf_wr_byte: got %h, required %h", o, e); end
    end
    exp_tx.delete();
    checks++;
    if (!got || d !== exp_rsp[0] || to !== 1'b0) begin
      errors++;
      $display("FAIL rf_wr_rsp: valid=%b data=%h timeout=%b, required 1 %h 0", got, d, to, exp_rsp[0]);
    end
    void'(exp_rsp.pop_front());
    @(negedge CLK);
    checks++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL rf_wr_done_one_cycle: rsp_valid=%b ready=%b, required 0 1", RSP_VALID, CMD_READY);
    end
  endtask

  task automatic test_rf_rd;
    bit got; logic [15:0] d; logic to; logic [7:0] e, o;
    tx_seen.delete();
    exp_tx.push_back(8'hBB); exp_tx.push_back(8'h02);
    exp_rsp.push_back(16'h0081);
    drive_cmd(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0, 2, 1, 8'h81, 8'h00, 1'b0, got, d, to);
    checks++;
    if (tx_seen.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL rf_rd_frame_len: got %0d bytes, required %0d", tx_seen.size(), exp_tx.size());
    end
    while (exp_tx.size() > 0 && tx_seen.size() > 0) begin
      e = exp_tx.pop_front(); o = tx_seen.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rf_rd_byte: got %h, required %h", o, e); end
    end
    exp_tx.delete();
    checks++;
    if (!got || d !== exp_rsp[0] || to !== 1'b0) begin
      errors++;
      $display("FAIL rf_rd_rsp: valid=%b data=%h timeout=%b, required 1 %h 0", got, d, to, exp_rsp[0]);
    end
    // A late byte after completion is discarded and the result is held.
    @(negedge CLK);
    send_rx(8'h77);
    repeat (3) @(negedge CLK);
    checks++;
    if (RSP_DATA !== exp_rsp[0]) begin
      errors++;
      $display("FAIL rf_rd_hold: rsp_data=%h, required %h", RSP_DATA, exp_rsp[0]);
    end
    void'(exp_rsp.pop_front());
  endtask

  task automatic test_alu_op;
    bit got; logic [15:0] d; logic to; logic [7:0] e, o;
    tx_seen.delete();
    exp_tx.push_back(8'hCC); exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h00);
    exp_rsp.push_back(16'h0046);
    drive_cmd(2'd2, 4'd0, 8'h00, 8'h12, 8'h34, 4'd0, 4, 2, 8'h46, 8'h00, 1'b0, got, d, to);
    checks++;
    if (tx_seen.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL alu_op_frame_len: got %0d bytes, required %0d", tx_seen.size(), exp_tx.size());
    end
    while (exp_tx.size() > 0 && tx_seen.size() > 0) begin
      e = exp_tx.pop_front(); o = tx_seen.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL alu_op_byte: got %h, required %h", o, e); end
    end
    exp_tx.delete();
    checks++;
    if (!got || d !== exp_rsp[0] || to !== 1'b0) begin
      errors++;
      $display("FAIL alu_op_rsp: valid=%b data=%h timeout=%b, required 1 %h 0", got, d, to, exp_rsp[0]);
    end
    void'(exp_rsp.pop_front());
  endtask

  task automatic test_alu_nop_stray;
    bit got; logic [15:0] d; logic to; logic [7:0] e, o;
    tx_seen.delete();
    exp_tx.push_back(8'hDD); exp_tx.push_back(8'h02);
    exp_rsp.push_back(16'h0348);
    drive_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd2, 2, 2, 8'h48, 8'h03, 1'b1, got, d, to);
    checks++;
    if (tx_seen.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL alu_nop_frame_len: got %0d bytes, required %0d", tx_seen.size(), exp_tx.size());
    end
    while (exp_tx.size() > 0 && tx_seen.size() > 0) begin
      e = exp_tx.pop_front(); o = tx_seen.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL alu_nop_byte: got %h, required %h", o, e); end
    end
    exp_tx.delete();
    checks++;
    if (!got || d !== exp_rsp[0] || to !== 1'b0) begin
      errors++;
      $display("FAIL alu_nop_rsp: valid=%b data=%h timeout=%b, required 1 %h 0", got, d, to, exp_rsp[0]);
    end
    void'(exp_rsp.pop_front());
  endtask

  task automatic test_reset_mid_cmd;
    bit got, seen_valid; logic [15:0] d; logic to; logic [7:0] e, o;
    tx_seen.delete();
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_TYPE = 2'd2; CMD_OP_A = 8'h12; CMD_OP_B = 8'h34; CMD_FUNC = 4'd0;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    for (int k = 0; k < 500 && tx_seen.size() < 2; k++) @(negedge CLK);
    for (int k = 0; k < 50 && !TX_BUSY; k++) @(negedge CLK);
    repeat (3) @(negedge CLK);   // transmitter busy: master sits in WAIT_LO
    RST = 1'b0;
    #1;
    checks++;
    if ({CMD_READY, TX_DATA_VALID, TX_DATA, RSP_DATA, RSP_VALID, RSP_TIMEOUT} !== {1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_outputs: ready=%b txv=%b tx=%h rsp=%h rv=%b to=%b, required 1 0 00 0000 0 0",
               CMD_READY, TX_DATA_VALID, TX_DATA, RSP_DATA, RSP_VALID, RSP_TIMEOUT);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (RSP_VALID) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_rsp: rsp_valid seen=%b, required 0", seen_valid);
    end
    for (int k = 0; k < 50 && TX_BUSY; k++) @(negedge CLK);
    tx_seen.delete();
    exp_tx.push_back(8'hBB); exp_tx.push_back(8'h05);
    exp_rsp.push_back(16'h003C);
    drive_cmd(2'd1, 4'd5, 8'h00, 8'h00, 8'h00, 4'd0, 2, 1, 8'h3C, 8'h00, 1'b0, got, d, to);
    checks++;
    if (tx_seen.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL post_reset_frame_len: got %0d bytes, required %0d", tx_seen.size(), exp_tx.size());
    end
    while (exp_tx.size() > 0 && tx_seen.size() > 0) begin
      e = exp_tx.pop_front(); o = tx_seen.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL post_reset_byte: got %h, required %h", o, e); end
    end
    exp_tx.delete();
    checks++;
    if (!got || d !== exp_rsp[0] || to !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_rsp: valid=%b data=%h timeout=%b, required 1 %h 0", got, d, to, exp_rsp[0]);
    end
    void'(exp_rsp.pop_front());
  endtask

`ifdef UART_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    bit got; logic [15:0] d; logic to;
    for (int k = 0; k < 50 && TX_BUSY; k++) @(negedge CLK);
    tx_seen.delete();
    exp_rsp.push_back(16'h0000);
    drive_cmd(2'd1, 4'd7, 8'h00, 8'h00, 8'h00, 4'd0, 2, 0, 8'h00, 8'h00, 1'b0, got, d, to);
    checks++;
    if (!got || to !== 1'b1 || d !== exp_rsp[0]) begin
      errors++;
      $display("FAIL timeout_rsp: valid=%b timeout=%b data=%h, required 1 1 %h", got, to, d, exp_rsp[0]);
    end
    void'(exp_rsp.pop_front());
  endtask
`endif

  initial begin
    test_reset();
    test_rf_wr();
    test_rf_rd();
    test_alu_op();
    test_alu_nop_stray();
    test_reset_mid_cmd();
`ifdef UART_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
